// File: rtl/fft_pkg.sv
// Shared FFT front-end types and constants.
// Complex sample bundle and framer read-side state encoding.
package fft_pkg;

  localparam int FFT_N      = 256;
  localparam int FFT_DATA_W = 32;

  typedef struct packed {
    logic [FFT_DATA_W-1:0] re;
    logic [FFT_DATA_W-1:0] img;
  } cplx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP
  } framer_state_t;

endpackage

// File: rtl/fft_sync_fifo.sv
// Single-clock FIFO of complex samples.
// Read data is registered; level is the registered occupancy.
module fft_sync_fifo
  import fft_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  cplx_t                    wr_data,
  input  logic                     rd_en,
  output cplx_t                    rd_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  cplx_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Storage array, no reset needed on the data itself
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      level <= level + LW'(wr_en) - LW'(rd_en);
    end
  end

endmodule

// File: rtl/fft_input_framer.sv
// Buffers a gappy sample stream and emits gapless N-sample frames.
// Optional zero padding of short source frames: FRAMER_ZERO_PAD_EN.
module fft_input_framer
  import fft_pkg::*;
#(
  parameter int N      = FFT_N,
  parameter int DATA_W = FFT_DATA_W,
  parameter int DEPTH  = 512,
  parameter int GAP    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_real,
  input  logic [DATA_W-1:0]        s_img,
  input  logic                     s_last,
  output logic                     start,
  output logic                     over,
  output logic [DATA_W-1:0]        data_out_real,
  output logic [DATA_W-1:0]        data_out_img,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(N);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [LW-1:0] LVL_N    = LW'(N);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] LAST     = CW'(N - 1);

  framer_state_t  state;
  logic [CW-1:0]  in_cnt;
  logic [CW-1:0]  out_cnt;
  logic [GW-1:0]  gap_cnt;
  logic           ready_en;
  logic           padding;
  logic           out_vld;
  logic           full;
  logic           accept;
  logic           wr;
  logic           rd;
  logic           launch;
  logic [LW-1:0]  lvl_nxt;
  cplx_t          wr_data;
  cplx_t          rd_q;

  assign full    = (fifo_level == LVL_FULL);
  assign s_ready = ready_en && !full && !padding;
  assign accept  = s_valid && s_ready;

`ifdef FRAMER_ZERO_PAD_EN
  assign wr      = accept || (padding && !full);
  assign wr_data = padding ? '0 : cplx_t'{re: s_real, img: s_img};

  // Fill a short source frame with zeros up to the N boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      padding <= 1'b0;
    end else if (accept && s_last && in_cnt != LAST) begin
      padding <= 1'b1;
    end else if (padding && !full && in_cnt == LAST) begin
      padding <= 1'b0;
    end
  end
`else
  logic unused_last;
  assign unused_last = s_last;
  assign padding     = 1'b0;
  assign wr          = accept;
  assign wr_data     = cplx_t'{re: s_real, img: s_img};
`endif

  // Write-side frame position and ready release after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (wr) in_cnt <= (in_cnt == LAST) ? '0 : in_cnt + 1'b1;
    end
  end

  assign launch  = (fifo_level >= LVL_N) && (gap_cnt == '0);
  assign lvl_nxt = fifo_level + LW'(wr) - LW'(rd);

  // Read strobe: launch from idle, or keep streaming in a frame
  always_comb begin
    rd = 1'b0;
    unique case (state)
      ST_IDLE: rd = launch;
      ST_RUN:  rd = 1'b1;
      default: rd = 1'b0;
    endcase
  end

  // Read-side FSM with markers aligned to the FIFO read data
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      out_cnt <= '0;
      gap_cnt <= '0;
      start   <= 1'b0;
      over    <= 1'b0;
      out_vld <= 1'b0;
    end else begin
      start   <= rd && (out_cnt == '0);
      over    <= rd && (out_cnt == LAST);
      out_vld <= rd;
      unique case (state)
        ST_IDLE: begin
          if (launch) begin
            state   <= ST_RUN;
            out_cnt <= CW'(1);
          end
        end
        ST_RUN: begin
          if (out_cnt == LAST) begin
            out_cnt <= '0;
            if (GAP > 0) begin
              state   <= ST_GAP;
              gap_cnt <= GW'(GAP);
            end else if (lvl_nxt >= LVL_N) begin
              state <= ST_RUN;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            out_cnt <= out_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt <= GW'(1)) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fft_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr),
    .wr_data (wr_data),
    .rd_en   (rd),
    .rd_data (rd_q),
    .level   (fifo_level)
  );

  assign data_out_real = out_vld ? rd_q.re  : '0;
  assign data_out_img  = out_vld ? rd_q.img : '0;

endmodule

// File: tb/tb_fft_input_framer.sv
// Directed bench for fft_input_framer (GAP=0 and GAP=1000 instances).
// Outputs are logged per cycle on the falling edge and checked afterwards.
module tb_fft_input_framer;

  localparam int N    = 256;
  localparam int W    = 32;
  localparam int D    = 512;
  localparam int LV   = 10;
  localparam int LOGN = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [W-1:0]  s_real = '0;
  logic [W-1:0]  s_img = '0;

  logic          a_ready, a_start, a_over;
  logic [W-1:0]  a_re, a_im;
  logic [LV-1:0] a_lvl;
  logic          b_ready, b_start, b_over;
  logic [W-1:0]  b_re, b_im;
  logic [LV-1:0] b_lvl;

  fft_input_framer #(.N(N), .DATA_W(W), .DEPTH(D), .GAP(0)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(a_ready),
    .s_real(s_real), .s_img(s_img), .s_last(s_last),
    .start(a_start), .over(a_over),
    .data_out_real(a_re), .data_out_img(a_im), .fifo_level(a_lvl)
  );

  fft_input_framer #(.N(N), .DATA_W(W), .DEPTH(D), .GAP(1000)) u_gap (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(b_ready),
    .s_real(s_real), .s_img(s_img), .s_last(s_last),
    .start(b_start), .over(b_over),
    .data_out_real(b_re), .data_out_img(b_im), .fifo_level(b_lvl)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          a_st_l [LOGN];
  logic          a_ov_l [LOGN];
  logic [W-1:0]  a_re_l [LOGN];
  logic [W-1:0]  a_im_l [LOGN];
  logic [LV-1:0] a_lv_l [LOGN];
  logic          b_st_l [LOGN];
  logic          b_ov_l [LOGN];
  logic [W-1:0]  b_re_l [LOGN];
  logic [W-1:0]  b_im_l [LOGN];
  logic [LV-1:0] b_lv_l [LOGN];
  logic          b_rd_l [LOGN];

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      a_st_l[cyc] <= a_start;
      a_ov_l[cyc] <= a_over;
      a_re_l[cyc] <= a_re;
      a_im_l[cyc] <= a_im;
      a_lv_l[cyc] <= a_lvl;
      b_st_l[cyc] <= b_start;
      b_ov_l[cyc] <= b_over;
      b_re_l[cyc] <= b_re;
      b_im_l[cyc] <= b_im;
      b_lv_l[cyc] <= b_lvl;
      b_rd_l[cyc] <= b_ready;
    end
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int off;
    bit st;
    bit ov;
    int v;
  } vec_t;

  vec_t tbl [7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input bit check_it);
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    tick();
    tick();
    if (check_it) begin
      chk("rst_ready", 64'(a_ready), 64'd0);
      chk("rst_flags", 64'({a_start, a_over}), 64'd0);
      chk("rst_data", 64'({a_re, a_im}), 64'd0);
      chk("rst_level", 64'(a_lvl), 64'd0);
    end
    rst = 1'b0;
    tick();
    if (check_it) chk("ready_after_rst", 64'(a_ready), 64'd1);
  endtask

  task automatic stream(input int n, input int last_at, input bit bursty);
    bit idle = 1'b0;
    for (int i = 0; i < n;) begin
      if (bursty && idle) begin
        s_valid = 1'b0;
        s_last = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_real = 32'(i);
        s_img = 32'(-i);
        s_last = (i == last_at);
        i++;
      end
      idle = !idle;
      tick();
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic find_start(input bit g, input int from, input int to,
                            output int s);
    s = -1;
    for (int t = from; t <= to && t < LOGN; t++) begin
      if ((g ? b_st_l[t] : a_st_l[t]) === 1'b1) begin
        s = t;
        break;
      end
    end
  endtask

  task automatic check_frame(input string nm, input bit g, input int s,
                             input int base, input int pad_from);
    bit    ok = 1'b1;
    string msg = "";
    if (s < 0 || s + N > LOGN) begin
      ok = 1'b0;
      msg = "no start found";
    end else begin
      for (int j = 0; j < N; j++) begin
        int v;
        logic st, ov;
        logic [W-1:0] re, im;
        v  = (j >= pad_from) ? 0 : base + j;
        st = g ? b_st_l[s+j] : a_st_l[s+j];
        ov = g ? b_ov_l[s+j] : a_ov_l[s+j];
        re = g ? b_re_l[s+j] : a_re_l[s+j];
        im = g ? b_im_l[s+j] : a_im_l[s+j];
        if (ok && (st !== (j == 0) || ov !== (j == N - 1) ||
                   re !== 32'(v) || im !== 32'(-v))) begin
          ok = 1'b0;
          msg = $sformatf("j=%0d got st=%b ov=%b re=%0h im=%0h, expected re=%0h im=%0h",
                          j, st, ov, re, im, 32'(v), 32'(-v));
        end
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", nm, msg);
    end
  endtask

  task automatic run_single(input string tag);
    int t0;
    t0 = cyc;
    stream(N, -1, 1'b0);
    wait_until(t0 + 516);
    for (int k = 0; k < 7; k++) begin
      int t;
      t = t0 + tbl[k].off;
      chk($sformatf("%s_flags_%0d", tag, tbl[k].off),
          64'({a_st_l[t], a_ov_l[t]}), 64'({tbl[k].st, tbl[k].ov}));
      chk($sformatf("%s_data_%0d", tag, tbl[k].off),
          64'({a_re_l[t], a_im_l[t]}),
          {32'(tbl[k].v), 32'(-tbl[k].v)});
    end
  endtask

  initial begin
    int t0, s1, s2, s3, seen, viol, idx, guard;
    bit acc;

    tbl = '{
      '{256, 1'b0, 1'b0, 0},
      '{257, 1'b1, 1'b0, 0},
      '{258, 1'b0, 1'b0, 1},
      '{385, 1'b0, 1'b0, 128},
      '{511, 1'b0, 1'b0, 254},
      '{512, 1'b0, 1'b1, 255},
      '{513, 1'b0, 1'b0, 0}
    };

    // single frame
    do_reset(1'b1);
    run_single("single");

    // back-to-back frames
    do_reset(1'b0);
    t0 = cyc;
    stream(2 * N, -1, 1'b0);
    wait_until(t0 + 1032);
    find_start(1'b0, t0, t0 + 1031, s1);
    chk("b2b_first_start", 64'(s1 - t0), 64'd257);
    check_frame("b2b_frame0", 1'b0, s1, 0, N);
    chk("b2b_second_start", 64'({a_st_l[t0+513], a_re_l[t0+513]}),
        {1'b1, 32'd256});
    check_frame("b2b_frame1", 1'b0, t0 + 513, 256, N);
    chk("b2b_level_end", 64'(a_lv_l[t0+1030]), 64'd0);

    // bursty input
    do_reset(1'b0);
    t0 = cyc;
    stream(N, -1, 1'b1);
    wait_until(t0 + 780);
    find_start(1'b0, t0, t0 + 779, s1);
    chk("burst_start", 64'(s1 - t0), 64'd512);
    check_frame("burst_frame", 1'b0, s1, 0, N);
    if (s1 >= 0)
      chk("burst_after", 64'({a_st_l[s1+N], a_ov_l[s1+N], a_re_l[s1+N]}),
          64'd0);

    // backpressure on the GAP=1000 instance
    do_reset(1'b0);
    t0 = cyc;
    idx = 0;
    guard = 0;
    while (idx < 800 && guard < 6000) begin
      s_valid = 1'b1;
      s_real = 32'(idx);
      s_img = 32'(-idx);
      acc = b_ready;
      tick();
      if (acc) idx++;
      guard++;
    end
    s_valid = 1'b0;
    chk("bp_accepted", 64'(idx), 64'd800);
    wait_until(t0 + 3100);
    seen = 0;
    viol = 0;
    for (int t = t0; t < t0 + 3100; t++) begin
      if (b_lv_l[t] == 10'(D)) begin
        seen++;
        if (b_rd_l[t] !== 1'b0) viol++;
      end
    end
    chk("bp_full_seen", 64'(seen > 0), 64'd1);
    chk("bp_ready_at_full", 64'(viol), 64'd0);
    find_start(1'b1, t0, t0 + 3099, s1);
    check_frame("bp_frame0", 1'b1, s1, 0, N);
    find_start(1'b1, s1 + N, t0 + 3099, s2);
    check_frame("bp_frame1", 1'b1, s2, 256, N);
    chk("bp_gap_len", 64'(s2 - (s1 + N - 1)), 64'd1001);
    find_start(1'b1, s2 + N, t0 + 3099, s3);
    check_frame("bp_frame2", 1'b1, s3, 512, N);
    chk("bp_level_end", 64'(b_lv_l[t0+3099]), 64'd32);

    // s_last on sample 99
    do_reset(1'b0);
    t0 = cyc;
`ifdef FRAMER_ZERO_PAD_EN
    stream(100, 99, 1'b0);
`else
    stream(N, 99, 1'b0);
`endif
    wait_until(t0 + 520);
    find_start(1'b0, t0, t0 + 519, s1);
    chk("last_start", 64'(s1 - t0), 64'd257);
`ifdef FRAMER_ZERO_PAD_EN
    check_frame("pad_frame", 1'b0, s1, 0, 100);
`else
    check_frame("nopad_frame", 1'b0, s1, 0, N);
`endif
    chk("last_level_end", 64'(a_lv_l[t0+515]), 64'd0);

    // reset mid-frame, then a fresh frame
    do_reset(1'b0);
    t0 = cyc;
    stream(N, -1, 1'b0);
    wait_until(t0 + 385);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("mid_sample128", 64'({a_st_l[t0+385], a_re_l[t0+385]}),
        {1'b0, 32'd128});
    chk("mid_outs_zero", 64'({a_st_l[t0+386], a_ov_l[t0+386],
                              a_re_l[t0+386], a_im_l[t0+386]}), 64'd0);
    chk("mid_level_zero", 64'(a_lv_l[t0+386]), 64'd0);
    chk("mid_ready_release", 64'(a_lv_l[t0+387] == 0 && b_rd_l[t0+387] === 1'b1),
        64'd1);
    run_single("fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
